// File: rtl/hilo_sched_if.sv
// Bundle-side connection of the HI/LO scheduler: per-lane requests from the
// memory stage, the flush strobe, and the stall / HI / LO / busy results.
interface hilo_sched_if;
    logic [1:0]       req_valid;
    logic [1:0][2:0]  req_op;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic             flush;
    logic             stall_o;
    logic [31:0]      hi_rd;
    logic [31:0]      lo_rd;
    logic             busy;

    // Pipeline side: presents the bundle, observes stall and HI/LO.
    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        input  stall_o, hi_rd, lo_rd, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        output stall_o, hi_rd, lo_rd, busy
    );
endinterface

// File: rtl/hilo_sched.sv
// HI/LO controller for the dual-issue pipeline. Serialises MULT/MULTU/DIV/DIVU/
// MTHI/MTLO from both lanes in lane order, using a pipelined multiplier and a
// restoring radix-2 divider, and stalls the bundle until every op has committed.
module hilo_sched #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hilo_sched_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [5:0] MUL_LAT_C  = 6'(MUL_LAT);
    localparam logic [5:0] DIV_ITER_C = 6'(DIV_ITER);

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [1:0]  served_q, served_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        mul_signed_q, mul_signed_d;

    logic [31:0] div_rem_q, div_rem_d;   // partial remainder
    logic [31:0] div_quo_q, div_quo_d;   // dividend shifting out, quotient shifting in
    logic [31:0] div_den_q, div_den_d;   // |divisor|
    logic [31:0] div_a_q, div_a_d;       // raw dividend, returned as HI on divide-by-zero
    logic        div_neg_q, div_neg_d;   // quotient must be negated
    logic        div_rneg_q, div_rneg_d; // remainder must be negated (dividend sign)
    logic        div_zero_q, div_zero_d;

    // Per-lane pending decode: valid, a real HI/LO op, and not yet committed.
    logic [1:0] lane_pending;
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_pending[gi] = bus.req_valid[gi]
                                  && (bus.req_op[gi] >= OP_MULT)
                                  && (bus.req_op[gi] <= OP_MTLO)
                                  && !served_q[gi];
    end

    logic        has_pending, sel_lane, sel_is_mt, stall_c;
    logic [2:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic        sel_a_neg, sel_b_neg;

    // Lane 0 is older, so it always wins when both are pending.
    assign has_pending = |lane_pending;
    assign sel_lane    = !lane_pending[0];
    assign sel_op      = bus.req_op[sel_lane];
    assign sel_a       = bus.req_a[sel_lane];
    assign sel_b       = bus.req_b[sel_lane];
    assign sel_is_mt   = (sel_op == OP_MTHI) || (sel_op == OP_MTLO);
    assign sel_a_neg   = (sel_op == OP_DIV) && sel_a[31];
    assign sel_b_neg   = (sel_op == OP_DIV) && sel_b[31];

    // A lone MTHI/MTLO commits in its issue cycle, so it needs no stall; while
    // reset is asserted every output is forced low.
    assign stall_c = rst_n && has_pending
                     && !((state_q == ST_IDLE) && (lane_pending != 2'b11) && sel_is_mt);

    // Multiplier: operands are extended to 64 bits (sign or zero) so a single
    // unsigned 64x64 product gives the correct low 64 bits for MULT and MULTU.
    logic [63:0] mul_ax, mul_bx, prod_c, mul_result;
    assign mul_ax = {{32{mul_signed_q & mul_a_q[31]}}, mul_a_q};
    assign mul_bx = {{32{mul_signed_q & mul_b_q[31]}}, mul_b_q};
    assign prod_c = mul_ax * mul_bx;

    if (MUL_LAT > 1) begin : g_mul_pipe
        logic [63:0] pipe_q [MUL_LAT-1];
        // Product pipeline; the last stage lines up with the count==MUL_LAT commit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < MUL_LAT-1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= prod_c;
                for (int i = 1; i < MUL_LAT-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign mul_result = pipe_q[MUL_LAT-2];
    end else begin : g_mul_comb
        assign mul_result = prod_c;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_step, quo_step, q_fin, r_fin;
    assign div_shift = {div_rem_q, div_quo_q[31]};
    assign div_ge    = div_shift >= {1'b0, div_den_q};
    assign rem_step  = div_ge ? (div_shift[31:0] - div_den_q) : div_shift[31:0];
    assign quo_step  = {div_quo_q[30:0], div_ge};
    assign q_fin     = div_neg_q  ? -quo_step : quo_step;
    assign r_fin     = div_rneg_q ? -rem_step : rem_step;

    // Next-state: op selection, multiply/divide sequencing, commit, flush override.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        served_d     = served_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        div_rem_d    = div_rem_q;
        div_quo_d    = div_quo_q;
        div_den_d    = div_den_q;
        div_a_d      = div_a_q;
        div_neg_d    = div_neg_q;
        div_rneg_d   = div_rneg_q;
        div_zero_d   = div_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (has_pending) begin
                    case (sel_op)
                        OP_MTHI: begin
                            hi_d = sel_a;
                            served_d[sel_lane] = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d = sel_a;
                            served_d[sel_lane] = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            mul_a_d      = sel_a;
                            mul_b_d      = sel_b;
                            mul_signed_d = (sel_op == OP_MULT);
                            state_d      = ST_MUL;
                            count_d      = 6'd1;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_rem_d  = '0;
                            div_quo_d  = sel_a_neg ? -sel_a : sel_a;
                            div_den_d  = sel_b_neg ? -sel_b : sel_b;
                            div_a_d    = sel_a;
                            div_neg_d  = sel_a_neg ^ sel_b_neg;
                            div_rneg_d = sel_a_neg;
                            div_zero_d = (sel_b == 32'd0);
                            state_d    = ST_DIV;
                            count_d    = 6'd1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (count_q == MUL_LAT_C) begin
                    {hi_d, lo_d}       = mul_result;
                    served_d[sel_lane] = 1'b1;
                    state_d            = ST_IDLE;
                    count_d            = '0;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
            ST_DIV: begin
                div_rem_d = rem_step;
                div_quo_d = quo_step;
                if (count_q == DIV_ITER_C) begin
                    lo_d               = div_zero_q ? 32'hFFFF_FFFF : q_fin;
                    hi_d               = div_zero_q ? div_a_q : r_fin;
                    served_d[sel_lane] = 1'b1;
                    state_d            = ST_IDLE;
                    count_d            = '0;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The bundle advances whenever stall drops, so its lanes start fresh.
        if (!stall_c) served_d = '0;
        // Flush beats everything, including a commit due this edge.
        if (bus.flush) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            served_d = '0;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            served_q     <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            div_rem_q    <= '0;
            div_quo_q    <= '0;
            div_den_q    <= '0;
            div_a_q      <= '0;
            div_neg_q    <= 1'b0;
            div_rneg_q   <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            served_q     <= served_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            div_rem_q    <= div_rem_d;
            div_quo_q    <= div_quo_d;
            div_den_q    <= div_den_d;
            div_a_q      <= div_a_d;
            div_neg_q    <= div_neg_d;
            div_rneg_q   <= div_rneg_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign bus.stall_o = stall_c;
    assign bus.hi_rd   = hi_q;
    assign bus.lo_rd   = lo_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: a bundle-level model predicts stall/busy/HI/LO for
// every cycle of each bundle; a negedge process compares them against the DUT.
module tb_hilo_sched;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_sched_if bus();

    hilo_sched #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectations for the current cycle, published by the driver.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_busy;
    logic [31:0] exp_hi, exp_lo;
    int          stall_total = 0;
    logic [31:0] samp_hi, samp_lo;

    // Compare process: every cycle the bench is driving a bundle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall_o", {31'b0, bus.stall_o}, {31'b0, exp_stall});
                chk("busy",    {31'b0, bus.busy},    {31'b0, exp_busy});
                chk("hi_rd",   bus.hi_rd, exp_hi);
                chk("lo_rd",   bus.lo_rd, exp_lo);
                if (bus.stall_o) stall_total++;
                samp_hi = bus.hi_rd;
                samp_lo = bus.lo_rd;
            end
        end
    end

    // Architectural HI/LO as the model sees them.
    logic [31:0] m_hi = '0, m_lo = '0;

    function automatic bit is_mt(input logic [2:0] op);  return op == 3'd5 || op == 3'd6; endfunction
    function automatic bit is_mul(input logic [2:0] op); return op == 3'd1 || op == 3'd2; endfunction
    function automatic bit is_div(input logic [2:0] op); return op == 3'd3 || op == 3'd4; endfunction

    task automatic model_commit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF;
                end else if (op == 3'd3) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    int last_stalls;

    // Present one bundle for as long as the model says it stays, checking every
    // cycle. flush_at / rst_at / probe_t are cycle offsets (-1 = none).
    task automatic run_bundle(input logic [1:0] v, input logic [2:0] op0, input logic [2:0] op1,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input int flush_at, input int rst_at, input int probe_t);
        logic [2:0]  op [2];
        logic [31:0] aa [2];
        logic [31:0] bb [2];
        int st [2];
        int ln [2];
        int sum, len_total, mark;
        bit last_mt, any;
        op[0] = op0; op[1] = op1; aa[0] = a0; aa[1] = a1; bb[0] = b0; bb[1] = b1;
        sum = 0; last_mt = 0; any = 0;
        for (int i = 0; i < 2; i++) begin
            st[i] = sum;
            ln[i] = 0;
            if (v[i] && (is_mt(op[i]) || is_mul(op[i]) || is_div(op[i]))) begin
                ln[i]   = is_mt(op[i]) ? 1 : (is_mul(op[i]) ? MUL_LAT + 1 : 33);
                sum    += ln[i];
                last_mt = is_mt(op[i]);
                any     = 1;
            end
        end
        // The bundle leaves in the first cycle stall drops; after a MUL/DIV that
        // is one IDLE cycle past the commit.
        len_total = !any ? 1 : (last_mt ? sum : sum + 1);
        bus.req_valid = v;
        bus.req_op[0] = op0; bus.req_op[1] = op1;
        bus.req_a[0]  = a0;  bus.req_a[1]  = a1;
        bus.req_b[0]  = b0;  bus.req_b[1]  = b1;
        mark = stall_total;
        for (int t = 0; t < len_total; t++) begin
            bus.flush = (t == flush_at);
            exp_stall = (t != len_total - 1);
            exp_busy  = 1'b0;
            for (int i = 0; i < 2; i++)
                if (ln[i] > 1 && t > st[i] && t <= st[i] + ln[i] - 1) exp_busy = 1'b1;
            exp_hi = m_hi;
            exp_lo = m_lo;
            chk_en = 1'b1;
            if (t == rst_at) begin
                #1;
                rst_n = 1'b0;
                bus.req_valid = 2'b00;
                exp_stall = 1'b0; exp_busy = 1'b0; exp_hi = '0; exp_lo = '0;
                #1;
                chk("rst_hi",   bus.hi_rd, 32'h0);
                chk("rst_lo",   bus.lo_rd, 32'h0);
                chk("rst_busy", {31'b0, bus.busy}, 32'h0);
                m_hi = '0; m_lo = '0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (t == probe_t) begin
                chk("probe_hi", samp_hi, 32'd2);
                chk("probe_lo", samp_lo, 32'd14);
            end
            if (t == flush_at) break;
            for (int i = 0; i < 2; i++)
                if (ln[i] > 0 && st[i] + ln[i] - 1 == t) model_commit(op[i], aa[i], bb[i]);
        end
        bus.flush = 1'b0;
        last_stalls = stall_total - mark;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 20);
            5: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi",    bus.hi_rd, 32'h0);
        chk("reset_lo",    bus.lo_rd, 32'h0);
        chk("reset_busy",  {31'b0, bus.busy}, 32'h0);
        chk("reset_stall", {31'b0, bus.stall_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MULT / MULTU -3 * 5
        run_bundle(2'b01, 3'd1, 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, -1, -1, -1);
        chk("mult_stalls", last_stalls, 32'd3);
        chk("mult_hi", bus.hi_rd, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo_rd, 32'hFFFF_FFF1);
        run_bundle(2'b01, 3'd2, 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0, -1, -1, -1);
        chk("multu_hi", bus.hi_rd, 32'h0000_0004);
        chk("multu_lo", bus.lo_rd, 32'hFFFF_FFF1);

        // Lane 1 DIV 7 / -2, then DIVU 7 / 2
        run_bundle(2'b10, 3'd0, 3'd3, 0, 0, 32'd7, 32'hFFFF_FFFE, -1, -1, -1);
        chk("div_stalls", last_stalls, 32'd33);
        chk("div_lo", bus.lo_rd, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi_rd, 32'd1);
        run_bundle(2'b01, 3'd4, 3'd0, 32'd7, 32'd2, 0, 0, -1, -1, -1);
        chk("divu_lo", bus.lo_rd, 32'd3);
        chk("divu_hi", bus.hi_rd, 32'd1);

        // MTHI/MTLO pair, and two MTHI in program order
        run_bundle(2'b11, 3'd5, 3'd6, 32'hA, 0, 32'hB, 0, -1, -1, -1);
        chk("mt_stalls", last_stalls, 32'd1);
        chk("mt_hi", bus.hi_rd, 32'hA);
        chk("mt_lo", bus.lo_rd, 32'hB);
        run_bundle(2'b11, 3'd5, 3'd5, 32'd1, 0, 32'd2, 0, -1, -1, -1);
        chk("mthi2_hi", bus.hi_rd, 32'd2);

        // DIV 100/7 then MULTU 3*4 in one bundle; DIV result probed at cycle 33
        run_bundle(2'b11, 3'd3, 3'd2, 32'd100, 32'd7, 32'd3, 32'd4, -1, -1, 33);
        chk("pair_stalls", last_stalls, 32'd36);
        chk("pair_hi", bus.hi_rd, 32'd0);
        chk("pair_lo", bus.lo_rd, 32'd12);

        // Divide by zero, then a flushed DIV leaves HI/LO untouched
        run_bundle(2'b01, 3'd3, 3'd0, 32'd5, 32'd0, 0, 0, -1, -1, -1);
        chk("div0_stalls", last_stalls, 32'd33);
        chk("div0_hi", bus.hi_rd, 32'd5);
        chk("div0_lo", bus.lo_rd, 32'hFFFF_FFFF);
        run_bundle(2'b01, 3'd3, 3'd0, 32'd99, 32'd4, 0, 0, 10, -1, -1);
        bus.req_valid = 2'b00;
        #1;
        chk("flush_busy",  {31'b0, bus.busy}, 32'h0);
        chk("flush_stall", {31'b0, bus.stall_o}, 32'h0);
        chk("flush_hi", bus.hi_rd, 32'd5);
        chk("flush_lo", bus.lo_rd, 32'hFFFF_FFFF);
        run_bundle(2'b00, 3'd0, 3'd0, 0, 0, 0, 0, -1, -1, -1);

        // Reset in the middle of a DIV after preloading 7/7
        run_bundle(2'b11, 3'd5, 3'd6, 32'd7, 0, 32'd7, 0, -1, -1, -1);
        run_bundle(2'b01, 3'd3, 3'd0, 32'd1000, 32'd3, 0, 0, -1, 20, -1);
        run_bundle(2'b01, 3'd6, 3'd0, 32'h55, 0, 0, 0, -1, -1, -1);
        chk("post_rst_lo", bus.lo_rd, 32'h55);
        chk("post_rst_hi", bus.hi_rd, 32'h0);

        // Randomized bundles with occasional flushes
        for (int n = 0; n < 150; n++) begin
            logic [1:0] v;
            logic [2:0] o0, o1;
            int fa;
            v  = 2'($urandom_range(0, 3));
            o0 = 3'($urandom_range(0, 7));
            o1 = 3'($urandom_range(0, 7));
            fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_bundle(v, o0, o1, rnd_val(), rnd_val(), rnd_val(), rnd_val(), fa, -1, -1);
        end

        chk_en = 1'b0;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
